// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel gradient-magnitude block.
// abs_sat works on a wide sign-extended operand so any gradient width up to ABS_MAX_W fits.
package sobel_pkg;

  localparam int WIDTH_D   = 8;
  localparam int DEPTH_D   = 16;
  localparam int HEIGHT_D  = 16;
  localparam int ABS_MAX_W = 64;

  // |v| for a w-bit signed value held sign-extended in v; the most negative code clamps to max positive.
  function automatic logic [ABS_MAX_W-1:0] abs_sat(input logic signed [ABS_MAX_W-1:0] v,
                                                   input int w);
    logic signed [ABS_MAX_W-1:0] lo;
    logic [ABS_MAX_W-1:0]        res;
    lo = -(ABS_MAX_W'(1) <<< (w - 1));
    if (v == lo)    res = (ABS_MAX_W'(1) << (w - 1)) - ABS_MAX_W'(1);
    else if (v < 0) res = -v;
    else            res = v;
    return res;
  endfunction

endpackage

// File: rtl/sobel_magnitude_pix_counter.sv
// Column/row position of the next accepted pixel, with border and end-of-frame flags.
// The flags describe the pixel being accepted this cycle, before the counters advance.
module pix_counter
  import sobel_pkg::*;
#(
  parameter int DEPTH_P  = DEPTH_D,
  parameter int HEIGHT_P = HEIGHT_D
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic adv_i,
  output logic border_o,
  output logic last_o
);

  localparam int CW = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
  localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          col_wrap;
  logic          row_wrap;

  assign col_wrap = (int'(col_q) == DEPTH_P - 1);
  assign row_wrap = (int'(row_q) == HEIGHT_P - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (adv_i) begin
      if (col_wrap) begin
        col_q <= '0;
        row_q <= row_wrap ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // A 3x3 window is incomplete until two full lines and two columns have been seen.
  assign border_o = (int'(col_q) < 2) || (int'(row_q) < 2);
  assign last_o   = col_wrap && row_wrap;

endmodule

// File: rtl/sobel_magnitude.sv
// Two-stage valid/ready pipeline: S1 takes absolute gradients, S2 produces the
// saturated L1 magnitude, edge flag and end-of-frame marker.
module sobel_magnitude
  import sobel_pkg::*;
#(
  parameter int WIDTH_P  = WIDTH_D,
  parameter int DEPTH_P  = DEPTH_D,
  parameter int HEIGHT_P = HEIGHT_D
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [2*WIDTH_P-1:0] gx_i,
  input  logic signed [2*WIDTH_P-1:0] gy_i,
  input  logic [WIDTH_P-1:0]        thresh_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [WIDTH_P-1:0]        mag_o,
  output logic                      edge_o,
  output logic                      last_o
);

  localparam int STAGES = 2;
  localparam int GW     = 2 * WIDTH_P;
  localparam int AW     = GW - 1;
  localparam int SW     = GW + 1;
  localparam logic [WIDTH_P-1:0] MAG_MAX = '1;

  typedef struct packed {
    logic [AW-1:0]      ax;
    logic [AW-1:0]      ay;
    logic [WIDTH_P-1:0] thr;
    logic               border;
    logic               last;
  } s1_t;

  typedef struct packed {
    logic [WIDTH_P-1:0] mag;
    logic               edg;
    logic               last;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [SW-1:0]   sum;
  logic            s2_adv;
  logic            acc;
  logic            cur_border;
  logic            cur_last;

  // S2 can take new data when empty or draining; S1 likewise when S2 makes room.
  assign s2_adv  = !vld_pipe[2] || ready_i;
  assign ready_o = !vld_pipe[1] || s2_adv;
  assign acc     = valid_i && ready_o;

  pix_counter #(
    .DEPTH_P (DEPTH_P),
    .HEIGHT_P(HEIGHT_P)
  ) u_pix_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .adv_i   (acc),
    .border_o(cur_border),
    .last_o  (cur_last)
  );

  always_comb begin
    s1_d        = '0;
    s1_d.ax     = AW'(abs_sat(ABS_MAX_W'(gx_i), GW));
    s1_d.ay     = AW'(abs_sat(ABS_MAX_W'(gy_i), GW));
    s1_d.thr    = thresh_i;
    s1_d.border = cur_border;
    s1_d.last   = cur_last;
  end

  // Border pixels still flow through but are forced to a non-edge zero.
  always_comb begin
    sum       = SW'(s1_q.ax) + SW'(s1_q.ay);
    s2_d      = '0;
    s2_d.last = s1_q.last;
    if (!s1_q.border) begin
      s2_d.mag = (sum > SW'(MAG_MAX)) ? MAG_MAX : sum[WIDTH_P-1:0];
      s2_d.edg = (s2_d.mag >= s1_q.thr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
    end else begin
      if (ready_o) vld_pipe[1] <= valid_i;
      if (s2_adv)  vld_pipe[2] <= vld_pipe[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc) s1_q <= s1_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                       s2_q <= '0;
    else if (s2_adv && vld_pipe[1])  s2_q <= s2_d;
  end

  assign valid_o = vld_pipe[2];
  assign mag_o   = s2_q.mag;
  assign edge_o  = s2_q.edg;
  assign last_o  = s2_q.last;

endmodule

// File: tb/tb_sobel_magnitude.sv
// Randomized bench for sobel_magnitude against a frame-position reference model.
module tb_sobel_magnitude;

  localparam int W = 8;
  localparam int D = 16;
  localparam int H = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_i = 1'b0;
  logic ready_i = 1'b1;
  logic signed [2*W-1:0] gx_i = '0;
  logic signed [2*W-1:0] gy_i = '0;
  logic [W-1:0] thresh_i = '0;
  logic ready_o, valid_o, edge_o, last_o;
  logic [W-1:0] mag_o;

  always #5 clk = ~clk;

  sobel_magnitude #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .gx_i(gx_i), .gy_i(gy_i), .thresh_i(thresh_i), .valid_o(valid_o),
    .ready_i(ready_i), .mag_o(mag_o), .edge_o(edge_o), .last_o(last_o)
  );

  typedef struct packed {
    logic [W-1:0] mag;
    logic         edg;
    logic         last;
  } out_t;

  typedef struct {
    logic fire;
    logic acc;
    logic rdy;
    logic vld;
    out_t act;
    out_t exp;
    int   lat;
  } obs_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mcol = 0;
  int   mrow = 0;
  out_t expq[$];
  int   stq[$];

  function automatic out_t model(input int gx, input int gy, input int th);
    int   ax, ay, s;
    out_t o;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (ax > 32767) ax = 32767;
    if (ay > 32767) ay = 32767;
    s = ax + ay;
    if (s > 255) s = 255;
    if (mcol < 2 || mrow < 2) begin
      o.mag = '0;
      o.edg = 1'b0;
    end else begin
      o.mag = 8'(s);
      o.edg = (s >= th);
    end
    o.last = (mcol == D - 1) && (mrow == H - 1);
    mcol++;
    if (mcol == D) begin
      mcol = 0;
      mrow = (mrow + 1) % H;
    end
    return o;
  endfunction

  function automatic int rnd_grad();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0)      return -32768;
    else if (r == 1) return 32767;
    else             return int'($urandom_range(0, 600)) - 300;
  endfunction

  task automatic cycle(input logic v, input int gx, input int gy, input int th,
                       input logic rdy, output obs_t ob);
    @(negedge clk);
    valid_i  = v;
    gx_i     = 16'(gx);
    gy_i     = 16'(gy);
    thresh_i = 8'(th);
    ready_i  = rdy;
    #1;
    ob.acc  = v && ready_o;
    ob.rdy  = ready_o;
    ob.vld  = valid_o;
    ob.fire = valid_o && rdy;
    ob.act  = {mag_o, edge_o, last_o};
    ob.exp  = '0;
    ob.lat  = -1;
    if (ob.fire) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_output: got %h, expected no output", ob.act);
      end else begin
        ob.exp = expq.pop_front();
        ob.lat = cyc - stq.pop_front();
      end
    end
    if (ob.acc) begin
      expq.push_back(model(gx, gy, th));
      stq.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst     = 1'b1;
    valid_i = 1'b0;
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    expq.delete();
    stq.delete();
    mcol = 0;
    mrow = 0;
  endtask

  task automatic drain(input string nm);
    obs_t ob;
    for (int i = 0; i < 20 && expq.size() > 0; i++) begin
      cycle(1'b0, 0, 0, 0, 1'b1, ob);
      if (ob.fire) begin
        n_chk++;
        if (ob.act !== ob.exp) begin
          n_fail++;
          $display("FAIL %s_drain: got %h expected %h", nm, ob.act, ob.exp);
        end
      end
    end
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: %0d outputs missing, expected 0", nm, expq.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b1; ready_i = 1'b0; gx_i = 16'sd100; gy_i = 16'sd100;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
    n_chk += 5;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
    if (mag_o !== '0)     begin n_fail++; $display("FAIL rst_mag: got %h expected 00", mag_o); end
    if (edge_o !== 1'b0)  begin n_fail++; $display("FAIL rst_edge: got %b expected 0", edge_o); end
    if (last_o !== 1'b0)  begin n_fail++; $display("FAIL rst_last: got %b expected 0", last_o); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", ready_o); end
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
  endtask

  task automatic test_vectors();
    int vx[3], vy[3], vt[3], em[3];
    int nin, nout, gx, gy, th;
    obs_t ob;
    vx = '{3, 200, -32768};  vy = '{-4, -100, 0};
    vt = '{7, 255, 0};       em = '{7, 255, 255};
    for (int k = 0; k < 3; k++) begin
      reset_dut();
      nin = 0;
      nout = 0;
      for (int c = 0; c < 200 && nout < 86; c++) begin
        if (nin == 85) begin
          gx = vx[k]; gy = vy[k]; th = vt[k];
        end else begin
          gx = int'($urandom_range(0, 40)) - 20;
          gy = int'($urandom_range(0, 40)) - 20;
          th = int'($urandom_range(0, 40));
        end
        cycle(nin < 86, gx, gy, th, 1'b1, ob);
        if (ob.acc) nin++;
        if (ob.fire) begin
          n_chk++;
          if (ob.act !== ob.exp || ob.lat != 2) begin
            n_fail++;
            $display("FAIL vec%0d_stream: got %h lat %0d expected %h lat 2", k, ob.act, ob.lat, ob.exp);
          end
          if (nout == 85) begin
            n_chk++;
            if (ob.act.mag !== 8'(em[k]) || ob.act.edg !== 1'b1) begin
              n_fail++;
              $display("FAIL vec%0d_target: got mag %0d edge %b expected mag %0d edge 1",
                       k, ob.act.mag, ob.act.edg, em[k]);
            end
          end
          nout++;
        end
      end
      n_chk++;
      if (nout != 86) begin
        n_fail++;
        $display("FAIL vec%0d_timeout: got %0d outputs expected 86", k, nout);
      end
    end
  endtask

  task automatic test_border();
    int nin, nout, r, cc;
    out_t sp;
    obs_t ob;
    reset_dut();
    nin = 0;
    nout = 0;
    for (int c = 0; c < 400 && nout < 256; c++) begin
      cycle(nin < 256, 50, 50, 10, 1'b1, ob);
      if (ob.acc) nin++;
      if (ob.fire) begin
        r  = nout / D;
        cc = nout % D;
        sp.mag  = (r < 2 || cc < 2) ? 8'd0 : 8'd100;
        sp.edg  = !(r < 2 || cc < 2);
        sp.last = (nout == 255);
        n_chk++;
        if (ob.act !== sp || ob.act !== ob.exp) begin
          n_fail++;
          $display("FAIL border_px%0d: got %h expected %h", nout, ob.act, sp);
        end
        nout++;
      end
    end
    n_chk++;
    if (nout != 256) begin
      n_fail++;
      $display("FAIL border_timeout: got %0d outputs expected 256", nout);
    end
  endtask

  task automatic test_backpressure();
    int   gxs[40], gys[40];
    int   nin, nout;
    logic rdy, stall_prev;
    out_t prev;
    obs_t ob;
    for (int i = 0; i < 40; i++) begin
      gxs[i] = i * 7 + 1;
      gys[i] = -i;
    end
    reset_dut();
    nin = 0;
    nout = 0;
    stall_prev = 1'b0;
    prev = '0;
    for (int c = 0; c < 120 && nout < 40; c++) begin
      rdy = !(c >= 10 && c < 15);
      cycle(nin < 40, (nin < 40) ? gxs[nin] : 0, (nin < 40) ? gys[nin] : 0, 20, rdy, ob);
      if (ob.acc) nin++;
      if (c >= 10 && c < 15) begin
        n_chk++;
        if (ob.rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready c%0d: got %b expected 0", c, ob.rdy);
        end
      end
      if (stall_prev) begin
        n_chk++;
        if (ob.vld !== 1'b1 || ob.act !== prev) begin
          n_fail++;
          $display("FAIL bp_hold c%0d: got vld %b %h expected vld 1 %h", c, ob.vld, ob.act, prev);
        end
      end
      stall_prev = ob.vld && !rdy;
      prev = ob.act;
      if (ob.fire) begin
        n_chk++;
        if (ob.act !== ob.exp) begin
          n_fail++;
          $display("FAIL bp_order out%0d: got %h expected %h", nout, ob.act, ob.exp);
        end
        nout++;
      end
    end
    n_chk++;
    if (nout != 40) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs expected 40", nout);
    end
  endtask

  task automatic test_reset_mid();
    int   nin, nout;
    obs_t ob;
    reset_dut();
    nin = 0;
    for (int c = 0; c < 100 && nin < 37; c++) begin
      cycle(1'b1, 60, -60, 30, 1'b1, ob);
      if (ob.acc) nin++;
      if (ob.fire) begin
        n_chk++;
        if (ob.act !== ob.exp) begin
          n_fail++;
          $display("FAIL rmid_pre: got %h expected %h", ob.act, ob.exp);
        end
      end
    end
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    expq.delete();
    stq.delete();
    mcol = 0;
    mrow = 0;
    @(negedge clk);
    #1;
    n_chk += 2;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", valid_o); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", ready_o); end
    nin = 0;
    nout = 0;
    for (int c = 0; c < 150 && nout < 48; c++) begin
      cycle(nin < 48, rnd_grad(), rnd_grad(), int'($urandom_range(0, 255)), 1'b1, ob);
      if (ob.acc) nin++;
      if (ob.fire) begin
        n_chk++;
        if (ob.act !== ob.exp || (nout < 32 && (ob.act.mag !== '0 || ob.act.edg !== 1'b0))) begin
          n_fail++;
          $display("FAIL rmid_post out%0d: got %h expected %h", nout, ob.act, ob.exp);
        end
        nout++;
      end
    end
    n_chk++;
    if (nout != 48) begin
      n_fail++;
      $display("FAIL rmid_count: got %0d outputs expected 48", nout);
    end
  endtask

  task automatic test_random();
    logic v, rdy, stall_prev;
    out_t prev;
    obs_t ob;
    reset_dut();
    stall_prev = 1'b0;
    prev = '0;
    for (int c = 0; c < 800; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      cycle(v, rnd_grad(), rnd_grad(), int'($urandom_range(0, 255)), rdy, ob);
      if (stall_prev) begin
        n_chk++;
        if (ob.vld !== 1'b1 || ob.act !== prev) begin
          n_fail++;
          $display("FAIL rnd_hold c%0d: got vld %b %h expected vld 1 %h", c, ob.vld, ob.act, prev);
        end
      end
      stall_prev = ob.vld && !rdy;
      prev = ob.act;
      if (ob.fire) begin
        n_chk++;
        if (ob.act !== ob.exp) begin
          n_fail++;
          $display("FAIL rnd_out c%0d: got %h expected %h", c, ob.act, ob.exp);
        end
      end
    end
    drain("rnd");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_border();
    test_backpressure();
    test_reset_mid();
    drain("rmid");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_magnitude.md
SOBEL_MAGNITUDE -- requirements
Module: sobel_magnitude

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8: input pixel width and output magnitude width.
REQ-002 SHALL have parameter DEPTH_P, default 16: pixels per image line.
REQ-003 SHALL have parameter HEIGHT_P, default 16: lines per frame.
REQ-004 SHALL have port clk_i  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port valid_i  input  1: upstream gradient pair valid.
REQ-007 SHALL have port ready_o  output  1: block can accept the current gradient pair.
REQ-008 SHALL have port gx_i  input  2*WIDTH_P signed: horizontal gradient.
REQ-009 SHALL have port gy_i  input  2*WIDTH_P signed: vertical gradient.
REQ-010 SHALL have port thresh_i  input  WIDTH_P unsigned: edge threshold, sampled with each accepted pair.
REQ-011 SHALL have port valid_o  output  1: output pixel valid.
REQ-012 SHALL have port ready_i  input  1: downstream accepts the output pixel.
REQ-013 SHALL have port mag_o  output  WIDTH_P unsigned: saturated L1 gradient magnitude.
REQ-014 SHALL have port edge_o  output  1: mag_o >= captured threshold.
REQ-015 SHALL have port last_o  output  1: output pixel is the final pixel of a frame.

Function
REQ-016 Input transfer SHALL occur on cycles where valid_i & ready_o; output transfer SHALL occur on cycles where valid_o & ready_i.
REQ-017 SHALL be a two-stage registered pipeline. S1 registers |gx_i| and |gy_i|, the threshold, the border flag and the last flag. S2 registers mag_o, edge_o and last_o.
REQ-018 With ready_i held high, the output for an accepted pair SHALL appear on valid_o exactly 2 cycles after acceptance; throughput SHALL be 1 pair per cycle.
REQ-019 A stage SHALL load when it is empty or when its content moves forward in the same cycle. ready_o SHALL equal !(S1 full & S2 full & !ready_i).
REQ-020 There SHALL be no combinational path from valid_i to valid_o. The only combinational input-to-output path SHALL be ready_i to ready_o.
REQ-021 While valid_o is high and ready_i is low, mag_o, edge_o, last_o and valid_o SHALL hold stable. No data SHALL be lost, duplicated or reordered.
REQ-022 Absolute value of -2^(2*WIDTH_P-1) SHALL saturate to 2^(2*WIDTH_P-1)-1.
REQ-023 The sum |gx|+|gy| SHALL be computed at 2*WIDTH_P+1 bits, then clamped to 2^WIDTH_P-1 for mag_o.
REQ-024 edge_o SHALL be 1 exactly when mag_o >= the thresh_i value captured with that pair.
REQ-025 Column counter col (0..DEPTH_P-1) SHALL advance on each input transfer. On wrap it SHALL return to 0 and advance row (0..HEIGHT_P-1). row SHALL wrap from HEIGHT_P-1 to 0.
REQ-026 Border: a pair accepted with col<2 or row<2 (incomplete 3x3 window) SHALL produce mag_o=0 and edge_o=0; it SHALL still be emitted as a valid output.
REQ-027 last_o SHALL be 1 only for the pair accepted at col=DEPTH_P-1 and row=HEIGHT_P-1.
REQ-028 Simultaneous input and output transfer with both stages full SHALL shift the pipeline by one without a bubble.

Reset
REQ-029 While rst_i is high at a clock edge, valid_o, mag_o, edge_o, last_o, both stage-valid flags, col and row SHALL be cleared to 0.
REQ-030 During reset, ready_o SHALL be 1 from the first cycle after reset.
REQ-031 Reset asserted mid-frame SHALL discard in-flight data; the next accepted pair SHALL be treated as col=0, row=0.

Structure
REQ-032 A shared package sobel_pkg SHALL hold the default width/depth/height constants and the saturation helper function (abs_sat).
REQ-033 The block SHALL be flat, with one natural sub-module: pix_counter (col/row counters with wrap and last detection).

Verification
REQ-034 Values below use WIDTH_P=8, DEPTH_P=HEIGHT_P=16, ready_i=1, with the pair accepted at row 5, col 5 unless stated.
  - gx=3, gy=-4, thresh=7 -> mag_o=7, edge_o=1, valid_o 2 cycles after accept.
  - gx=200, gy=-100, thresh=255 -> mag_o=255 (saturated), edge_o=1.
  - gx=-32768, gy=0 -> mag_o=255, no overflow wrap.
REQ-035 Border test: stream 256 pairs, each gx=50, gy=50, thresh=10. Required outputs:
  - rows 0-1 and cols 0-1 -> mag_o=0, edge_o=0;
  - all other pixels -> mag_o=100, edge_o=1;
  - last_o high only on the 256th output.
REQ-036 Backpressure test: continuous valid_i, ready_i low for 5 cycles mid-stream. Required: ready_o drops after both stages fill, outputs hold stable, and the sequence matches the input order exactly with no gaps or duplicates.
REQ-037 Reset test: assert rst_i for 1 cycle after 37 pairs. Required: valid_o=0 next cycle, and after reset the first 32 outputs (2 lines) are border-zeroed.
